// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// multiply and restoring divide, result and flags held until accepted.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
  logic [CW-1:0]    cnt;
  logic             accept, last_step;

  logic [WIDTH:0]   mul_sum, div_shift, add_w, sub_w;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  logic [SHW-1:0]   amt;
  int unsigned      rot;
  logic [WIDTH-1:0] fin_result, fin_hi;
  logic             fin_carry, fin_ovf, fin_dz;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus combinational step/result values for the datapath
  always_comb begin
    state_next = state;
    accept     = in_valid && in_ready;
    last_step  = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (accept) begin
          if (select == 4'h2)                       state_next = MUL;
          else if (select == 4'h3 && B != '0)       state_next = DIV;
          else                                      state_next = DONE;
        end
      end
      MUL, DIV: if (last_step) state_next = DONE;
      DONE:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = WIDTH'(div_shift - {1'b0, opnd});
    if (state == MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end

    amt        = B[SHW-1:0];
    rot        = 32'(amt) % WIDTH;
    add_w      = {1'b0, A} + {1'b0, B};
    sub_w      = {1'b0, A} - {1'b0, B};
    fin_result = '0;
    fin_hi     = '0;
    fin_carry  = 1'b0;
    fin_ovf    = 1'b0;
    fin_dz     = 1'b0;
    if (state == MUL || state == DIV) begin
      fin_result = step_lo;
      fin_hi     = step_hi;
      fin_carry  = (state == MUL) && (step_hi != '0);
    end else begin
      case (select)
        4'h0: begin
          fin_result = add_w[WIDTH-1:0];
          fin_carry  = add_w[WIDTH];
          fin_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (fin_result[WIDTH-1] != A[WIDTH-1]);
        end
        4'h1: begin
          fin_result = sub_w[WIDTH-1:0];
          fin_carry  = sub_w[WIDTH];
          fin_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (fin_result[WIDTH-1] != A[WIDTH-1]);
        end
        4'h3: begin
          fin_result = '1;
          fin_hi     = A;
          fin_dz     = 1'b1;
        end
        4'h4: fin_result = A << amt;
        4'h5: fin_result = A >> amt;
        4'h6: fin_result = (A << rot) | (A >> (WIDTH - rot));
        4'h7: fin_result = (A >> rot) | (A << (WIDTH - rot));
        4'h8: fin_result = A & B;
        4'h9: fin_result = A | B;
        4'hA: fin_result = A ^ B;
        4'hB: fin_result = ~(A & B);
        4'hC: fin_result = ~(A | B);
        4'hD: fin_result = ~(A ^ B);
        4'hE: fin_result = WIDTH'(A > B);
        4'hF: fin_result = WIDTH'(A == B);
        default: fin_result = '0;
      endcase
    end
  end

  // Operand capture, iterative engine and held result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      opnd      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (state == IDLE && (state_next == MUL || state_next == DIV)) begin
        opnd   <= (state_next == MUL) ? A : B;
        acc_hi <= '0;
        acc_lo <= (state_next == MUL) ? B : A;
        cnt    <= '0;
      end else if (state == MUL || state == DIV) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt + CW'(1);
      end
      if (state != DONE && state_next == DONE) begin
        result    <= fin_result;
        result_hi <= fin_hi;
        carry     <= fin_carry;
        overflow  <= fin_ovf;
        zero      <= (fin_result == '0);
        negative  <= fin_result[WIDTH-1];
        div_zero  <= fin_dz;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH 8, 16 and 4: directed vectors, reset cases,
// backpressure and a random op stream against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [3:0]  select;
  logic [31:0] a_in, b_in;
  int          cur;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  logic iv8, iv16, iv4;
  assign iv8  = in_valid && (cur == 8);
  assign iv16 = in_valid && (cur == 16);
  assign iv4  = in_valid && (cur == 4);

  logic        ir8, ov8, c8, v8, z8, n8, d8;
  logic [7:0]  r8, h8;
  logic        ir16, ov16, c16, v16, z16, n16, d16;
  logic [15:0] r16, h16;
  logic        ir4, ov4, c4, v4, z4, n4, d4;
  logic [3:0]  r4, h4;

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a_in[7:0]), .B(b_in[7:0]),
    .select(select), .out_valid(ov8), .out_ready(out_ready), .result(r8), .result_hi(h8),
    .carry(c8), .overflow(v8), .zero(z8), .negative(n8), .div_zero(d8));

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a_in[15:0]), .B(b_in[15:0]),
    .select(select), .out_valid(ov16), .out_ready(out_ready), .result(r16), .result_hi(h16),
    .carry(c16), .overflow(v16), .zero(z16), .negative(n16), .div_zero(d16));

  alu_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a_in[3:0]), .B(b_in[3:0]),
    .select(select), .out_valid(ov4), .out_ready(out_ready), .result(r4), .result_hi(h4),
    .carry(c4), .overflow(v4), .zero(z4), .negative(n4), .div_zero(d4));

  logic        o_ir, o_ov, o_c, o_v, o_z, o_n, o_d;
  logic [31:0] o_r, o_h;

  always_comb begin
    o_ir = ir8; o_ov = ov8; o_r = 32'(r8); o_h = 32'(h8);
    o_c = c8; o_v = v8; o_z = z8; o_n = n8; o_d = d8;
    if (cur == 16) begin
      o_ir = ir16; o_ov = ov16; o_r = 32'(r16); o_h = 32'(h16);
      o_c = c16; o_v = v16; o_z = z16; o_n = n16; o_d = d16;
    end else if (cur == 4) begin
      o_ir = ir4; o_ov = ov4; o_r = 32'(r4); o_h = 32'(h4);
      o_c = c4; o_v = v4; o_z = z4; o_n = n4; o_d = d4;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint to_signed(input longint unsigned x, input int w);
    longint unsigned m = (64'd1 << w);
    return (((x >> (w - 1)) & 64'd1) != 0) ? longint'(x) - longint'(m) : longint'(x);
  endfunction

  // Reference: plain arithmetic on wide integers, masked to the operand width
  function automatic void ref_op(input int w, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r,
                                 output logic [31:0] hi, output logic c, output logic v,
                                 output logic dz);
    longint unsigned m, aa, bb, x;
    longint sa, sb, sx, half;
    int k;
    m = (64'd1 << w) - 64'd1;
    aa = 64'(a) & m;
    bb = 64'(b) & m;
    sa = to_signed(aa, w);
    sb = to_signed(bb, w);
    half = longint'(m + 64'd1) / 2;
    k = int'(bb % 64'(w));
    hi = '0; c = 1'b0; v = 1'b0; dz = 1'b0; x = 0;
    case (op)
      4'h0: begin x = aa + bb; c = (x > m); sx = sa + sb; v = (sx >= half) || (sx < -half); end
      4'h1: begin x = aa - bb; c = (aa < bb); sx = sa - sb; v = (sx >= half) || (sx < -half); end
      4'h2: begin x = aa * bb; hi = 32'((x >> w) & m); c = (hi != 0); end
      4'h3: begin
        if (bb == 0) begin x = m; hi = 32'(aa); dz = 1'b1; end
        else begin x = aa / bb; hi = 32'(aa % bb); end
      end
      4'h4: x = aa << k;
      4'h5: x = aa >> k;
      4'h6: x = (aa << k) | (aa >> (w - k));
      4'h7: x = (aa >> k) | (aa << (w - k));
      4'h8: x = aa & bb;
      4'h9: x = aa | bb;
      4'hA: x = aa ^ bb;
      4'hB: x = ~(aa & bb);
      4'hC: x = ~(aa | bb);
      4'hD: x = ~(aa ^ bb);
      4'hE: x = (aa > bb) ? 64'd1 : 64'd0;
      default: x = (aa == bb) ? 64'd1 : 64'd0;
    endcase
    r = 32'(x & m);
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int bp, input bit early,
                        output logic [31:0] got_r, output logic [31:0] got_h);
    logic [31:0] er, eh;
    logic ec, ev, ed;
    int n, lat, el;
    string t;
    ref_op(cur, op, a, b, er, eh, ec, ev, ed);
    el = (op == 4'h2 || (op == 4'h3 && (b & ((32'd1 << cur) - 1)) != 0)) ? cur + 1 : 1;
    t = $sformatf("w%0d op%0h a%0h b%0h", cur, op, a, b);
    n = 0;
    while (!o_ir && n < 100) begin @(negedge clk); n++; end
    check({t, " in_ready_wait"}, 32'(o_ir), 32'd1);
    a_in = a; b_in = b; select = op; in_valid = 1'b1; out_ready = early;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!o_ov && lat < 100) begin
      a_in = $urandom; b_in = $urandom; select = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    check({t, " latency"}, 32'(lat), 32'(el));
    if (!early && bp > 0) begin
      repeat (bp) @(negedge clk);
      check({t, " held_valid"}, 32'(o_ov), 32'd1);
      check({t, " held_in_ready"}, 32'(o_ir), 32'd0);
    end
    got_r = o_r; got_h = o_h;
    check({t, " result"}, o_r, er);
    check({t, " result_hi"}, o_h, eh);
    check({t, " flags cvznd"}, 32'({o_c, o_v, o_z, o_n, o_d}),
          32'({ec, ev, (er == 0), er[cur-1], ed}));
    out_ready = 1'b1;
    @(negedge clk);
    check({t, " post_out_valid"}, 32'(o_ov), 32'd0);
    check({t, " post_in_ready"}, 32'(o_ir), 32'd1);
    out_ready = 1'b0;
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a, b, er, eh; } vec_t;
  vec_t dir[12] = '{
    '{4'h0, 32'hFF, 32'h01, 32'h00, 32'h00}, '{4'h0, 32'h7F, 32'h01, 32'h80, 32'h00},
    '{4'h1, 32'h03, 32'h05, 32'hFE, 32'h00}, '{4'h2, 32'hFF, 32'hFF, 32'h01, 32'hFE},
    '{4'h3, 32'd200, 32'd7, 32'd28, 32'd4},  '{4'h3, 32'h55, 32'h00, 32'hFF, 32'h55},
    '{4'h6, 32'h81, 32'h01, 32'h03, 32'h00}, '{4'h7, 32'h01, 32'h03, 32'h20, 32'h00},
    '{4'h5, 32'h80, 32'h07, 32'h01, 32'h00}, '{4'hD, 32'hF0, 32'hF0, 32'hFF, 32'h00},
    '{4'hE, 32'h05, 32'h05, 32'h00, 32'h00}, '{4'hF, 32'h05, 32'h05, 32'h01, 32'h00}};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int widths[3] = '{8, 16, 4};
    logic [31:0] gr, gh;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; select = 4'h0;
    a_in = '0; b_in = '0; cur = 8;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (widths[i]) begin
      cur = widths[i];
      #1;
      check($sformatf("w%0d reset in_ready", cur), 32'(o_ir), 32'd1);
      check($sformatf("w%0d reset out_valid", cur), 32'(o_ov), 32'd0);
      check($sformatf("w%0d reset outputs", cur),
            o_r | o_h | 32'({o_c, o_v, o_z, o_n, o_d}), 32'd0);
    end
    @(negedge clk);

    cur = 8;
    foreach (dir[i]) begin
      run_op(dir[i].op, dir[i].a, dir[i].b, 0, 1'b0, gr, gh);
      check($sformatf("directed %0d result", i), gr, dir[i].er);
      check($sformatf("directed %0d result_hi", i), gh, dir[i].eh);
    end

    // Reset in the fourth MUL cycle discards the product
    a_in = 32'hFF; b_in = 32'hFF; select = 4'h2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_mul_rst in_ready", 32'(o_ir), 32'd1);
    check("mid_mul_rst out_valid", 32'(o_ov), 32'd0);
    check("mid_mul_rst outputs", o_r | o_h | 32'({o_c, o_v, o_z, o_n, o_d}), 32'd0);
    seen = 0;
    repeat (12) begin @(negedge clk); if (o_ov) seen++; end
    check("mid_mul_rst stale_valid", 32'(seen), 32'd0);

    foreach (widths[i]) begin
      cur = widths[i];
      run_op(4'h2, $urandom, $urandom, 10, 1'b0, gr, gh);
      run_op(4'h0, $urandom, $urandom, 10, 1'b0, gr, gh);
      repeat (40) begin
        logic [3:0] op;
        logic [31:0] b;
        op = 4'($urandom_range(0, 15));
        b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        run_op(op, $urandom, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), gr, gh);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit single-cycle ALU. Operands are captured on a valid/ready handshake and the result is held with status flags until the consumer accepts it. Multiply and divide run as iterative WIDTH-cycle engines: multiply returns the full double-width product, divide returns quotient and remainder. The block sits between the register-file read stage and the writeback stage of the team's small datapath.

## Interface
- WIDTH, 8, operand/result width; legal values are 4 to 32.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high. One clock; no other clock or reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- A  in  WIDTH  operand A (unsigned unless stated).
- B  in  WIDTH  operand B; for shifts/rotates, B[SHW-1:0] is the amount.
- select  in  4  opcode (encoding below).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result.
- result_hi  out  WIDTH  high product half (MUL), remainder (DIV), else 0.
- carry  out  1  add carry-out; sub borrow (A<B); MUL: result_hi≠0; else 0.
- overflow  out  1  signed overflow for ADD/SUB only; else 0.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- div_zero  out  1  DIV with B == 0.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL by amt, 5 SHR (logical) by amt, 6 ROL by amt, 7 ROR by amt, 8 AND, 9 OR, A XOR, B NAND, C NOR, D XNOR, E GT (A>B unsigned → 1 else 0), F EQ (A==B → 1 else 0).
- Operands and opcode are registered on accept (in_valid & in_ready). Later input changes have no effect on an operation in flight.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE on accept of any op other than MUL/DIV; the result is computed into the output registers.
  - IDLE → MUL on accept of MUL: shift-add, one bit per cycle, WIDTH cycles, then → DONE.
  - IDLE → DIV on accept of DIV with B≠0: restoring division, one quotient bit per cycle, WIDTH cycles, then → DONE.
  - IDLE → DONE on accept of DIV with B==0: result = all ones, result_hi = A, div_zero = 1.
  - DONE → IDLE on out_valid & out_ready.
- Result, result_hi and all flags are registered and stable throughout DONE. zero and negative are derived from result for every op.
- Rotates by amt 0 and shifts by amt 0 return A unchanged. Rotation is modulo WIDTH.
- ADD/SUB results wrap modulo 2^WIDTH.

## Timing
- Reset: state IDLE. in_ready=1 from the first cycle after reset. out_valid, result, result_hi and all flags are 0.
- rst asserted in any state, including mid-MUL/DIV or in DONE with out_valid high: the next cycle is IDLE with all outputs 0. The in-flight result is discarded and never presented.
- Accept at edge N.
  - Single-cycle ops and DIV-by-zero: out_valid=1 from edge N+1.
  - MUL/DIV: out_valid=1 from edge N+1+WIDTH (N+9 for WIDTH=8).
- in_ready=0 in MUL, DIV and DONE. No accept occurs in the cycle the result handshake completes.
- out_ready may be held high in advance. The handshake completes in the first DONE cycle, and in_ready rises on the following edge.
- Back-to-back throughput for single-cycle ops: one op per 2 cycles.
- out_ready high outside DONE is ignored.

## Test plan
- Reset then idle: rst high for 2 cycles → in_ready=1, out_valid=0, all outputs 0. Assert rst during MUL cycle 4 → IDLE on the next cycle, no out_valid.
- ADD/SUB flags (WIDTH=8): ADD 0xFF+0x01 → result 0x00, carry=1, zero=1. ADD 0x7F+0x01 → 0x80, overflow=1, negative=1. SUB 0x03−0x05 → 0xFE, carry=1. Each gives out_valid exactly 1 cycle after accept.
- MUL: 0xFF×0xFF → result 0x01, result_hi 0xFE, carry=1. out_valid appears exactly 9 cycles after accept. Change A/B mid-operation → result unchanged.
- DIV: 200/7 → result 28, result_hi 4, div_zero=0, after 9 cycles. 0x55/0 → result 0xFF, result_hi 0x55, div_zero=1, after 1 cycle.
- Shift/rotate/logic/compare: ROL 0x81 amt 1 → 0x03. ROR 0x01 amt 3 → 0x20. SHR 0x80 amt 7 → 0x01. XNOR 0xF0,0xF0 → 0xFF. GT 5,5 → 0. EQ 5,5 → 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0. Raise out_ready → in_ready=1 on the next edge. Repeat at WIDTH=16 and WIDTH=4; a random op stream is checked against a reference model.
